// File: rtl/ctr_keystream_ctrl_pkg.sv
// Shared definitions for the AES-CTR keystream path: block geometry, the
// sequencer state encoding and a byte-reversal helper that the upstream
// key/counter register block also uses.
package ctr_keystream_ctrl_pkg;

  localparam int unsigned KS_WORDS     = 4;
  localparam int unsigned KS_WORD_SIZE = 32;
  localparam int unsigned BLOCK_SIZE   = KS_WORDS * KS_WORD_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } ks_state_e;

  // Reverse the byte order of one bus word (BE <-> LE).
  function automatic logic [KS_WORD_SIZE-1:0] bswap_word(input logic [KS_WORD_SIZE-1:0] w);
    logic [KS_WORD_SIZE-1:0] r;
    r = '0;
    for (int b = 0; b < int'(KS_WORD_SIZE / 8); b++) begin
      r[b*8 +: 8] = w[(int'(KS_WORD_SIZE / 8) - 1 - b)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ctr_keystream_ctrl_if.sv
// Valid/ready data stream around the keystream XOR: the input side carries
// plaintext or ciphertext words in, the output side carries the XORed words out.
interface ctr_keystream_ctrl_if #(
  parameter int unsigned WORD_SIZE = 32
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;

  // Data source / sink side (bus FIFO and consumer).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Keystream controller side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/ctr_keystream_ctrl_bswap.sv
// Combinational byte reversal of one bus word; one instance per keystream word.
module word_bswap
  import ctr_keystream_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE = KS_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] word_i,
  output logic [WORD_SIZE-1:0] word_o
);

  localparam int unsigned NBYTES = WORD_SIZE / 8;

  for (genvar b = 0; b < int'(NBYTES); b++) begin : g_byte
    assign word_o[b*8 +: 8] = word_i[(int'(NBYTES) - 1 - b)*8 +: 8];
  end

endmodule

// File: rtl/ctr_keystream_ctrl.sv
// AES-CTR sequencer: snapshots the counter block, launches one encryption,
// pulses the counter increment, then XORs the buffered keystream word by
// word into the valid/ready data stream.
module ctr_keystream_ctrl
  import ctr_keystream_ctrl_pkg::*;
#(
  parameter int unsigned WORDS     = KS_WORDS,
  parameter int unsigned WORD_SIZE = KS_WORD_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         flush_i,
  input  logic [WORDS*WORD_SIZE-1:0]   ctr_block_i,
  output logic                         ctr_inc_o,
  output logic                         aes_start_o,
  output logic [WORDS*WORD_SIZE-1:0]   aes_in_o,
  input  logic                         aes_done_i,
  input  logic [WORDS*WORD_SIZE-1:0]   aes_out_i,
  ctr_keystream_ctrl_if.slave          strm,
  output logic                         busy_o,
  output logic [31:0]                  blk_count_o
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  ks_state_e                    state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [WORDS*WORD_SIZE-1:0]   ks_q;
  logic [WORDS*WORD_SIZE-1:0]   aes_in_q;
  logic                         aes_start_q;
  logic                         ctr_inc_q;
  logic                         out_valid_q;
  logic [WORD_SIZE-1:0]         out_data_q;
  logic [31:0]                  blk_count_q;

  logic [WORD_SIZE-1:0]         ks_word_s [WORDS];
  logic [WORD_SIZE-1:0]         ks_sel_s;
  logic                         in_ready_s;
  logic                         accept_s;
  logic                         last_s;
  logic                         launch_s;

  // Keystream words are stored BE with word0 in the MSBs; undo the upstream
  // word order and byte swap so each word lines up with an LE bus word.
  for (genvar gi = 0; gi < int'(WORDS); gi++) begin : g_bswap
    word_bswap #(.WORD_SIZE(WORD_SIZE)) u_bswap (
      .word_i (ks_q[(int'(WORDS) - gi)*int'(WORD_SIZE) - 1 -: WORD_SIZE]),
      .word_o (ks_word_s[gi])
    );
  end

  // Handshake decode: accept only while streaming and not being flushed,
  // and decide whether this cycle starts a new block.
  always_comb begin
    in_ready_s = 1'b0;
    ks_sel_s   = ks_word_s[idx_q];
    if ((state_q == ST_STREAM) && !flush_i) begin
      in_ready_s = !out_valid_q || strm.out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = strm.in_valid && in_ready_s;
    last_s   = accept_s && (idx_q == IDX_W'(WORDS - 1));
    launch_s = !flush_i && enable_i && strm.in_valid &&
               ((state_q == ST_IDLE) || last_s);
  end

  // Sequencer FSM, word index, launch pulses and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ks_q        <= '0;
      aes_in_q    <= '0;
      aes_start_q <= 1'b0;
      ctr_inc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      blk_count_q <= 32'd0;
    end else begin
      aes_start_q <= 1'b0;
      ctr_inc_q   <= 1'b0;

      // The output register drains regardless of state, flush included.
      if (accept_s) begin
        out_data_q  <= strm.in_data ^ ks_sel_s;
        out_valid_q <= 1'b1;
      end else if (strm.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Snapshot and pulses are registered on entry to LAUNCH so that
      // aes_start, ctr_inc and aes_in are all presented during LAUNCH.
      if (launch_s) begin
        aes_start_q <= 1'b1;
        ctr_inc_q   <= 1'b1;
        aes_in_q    <= ctr_block_i;
        blk_count_q <= blk_count_q + 32'd1;
      end

      if (flush_i) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        ks_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (launch_s) state_q <= ST_LAUNCH;
          end
          ST_LAUNCH: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (aes_done_i) begin
              ks_q    <= aes_out_i;
              idx_q   <= '0;
              state_q <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (last_s) begin
              idx_q   <= '0;
              state_q <= launch_s ? ST_LAUNCH : ST_IDLE;
            end else if (accept_s) begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ctr_inc_o      = ctr_inc_q;
  assign aes_start_o    = aes_start_q;
  assign aes_in_o       = aes_in_q;
  assign blk_count_o    = blk_count_q;
  assign busy_o         = (state_q != ST_IDLE) || out_valid_q;
  assign strm.in_ready  = in_ready_s;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;

endmodule

// File: tb/tb_ctr_keystream_ctrl.sv
// Directed bench for ctr_keystream_ctrl with an AES latency model, an upstream
// counter model and a scoreboard of expected output words.
module tb_ctr_keystream_ctrl;
  import ctr_keystream_ctrl_pkg::*;

  localparam logic [127:0] KCONST = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         enable    = 1'b0;
  logic         flush     = 1'b0;
  logic [127:0] ctr_block = 128'h0;
  logic         ctr_inc;
  logic         aes_start;
  logic [127:0] aes_in;
  logic         aes_done  = 1'b0;
  logic [127:0] aes_out   = 128'h0;
  logic         busy;
  logic [31:0]  blk_count;

  ctr_keystream_ctrl_if #(.WORD_SIZE(32)) strm ();

  ctr_keystream_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .flush_i     (flush),
    .ctr_block_i (ctr_block),
    .ctr_inc_o   (ctr_inc),
    .aes_start_o (aes_start),
    .aes_in_o    (aes_in),
    .aes_done_i  (aes_done),
    .aes_out_i   (aes_out),
    .strm        (strm),
    .busy_o      (busy),
    .blk_count_o (blk_count)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [31:0]  sb_q[$];
  logic [127:0] ain_q[$];
  int           starts  = 0;
  int           inc_cnt = 0;
  logic [127:0] exp_ctr = 128'h0;
  logic [127:0] exp_ks  = 128'h0;
  int           widx    = 0;
  logic [127:0] aes_blk;
  logic [31:0]  mon_exp;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Keystream word i for an LE bus: word i of the BE block, bytes reversed.
  function automatic logic [31:0] ksw(input logic [127:0] ks, input int i);
    logic [31:0] w;
    w = ks[(4-i)*32-1 -: 32];
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Upstream counter register: advances on each ctr_inc pulse.
  always @(posedge clk) begin
    if (ctr_inc) ctr_block <= ctr_block + 128'd1;
  end

  // Count increment pulses.
  always @(negedge clk) begin
    if (ctr_inc) inc_cnt++;
  end

  // AES model: 10-cycle latency, output = input ^ KCONST.
  always begin
    @(negedge clk);
    if (aes_start) begin
      aes_blk = aes_in;
      starts++;
      ain_q.push_back(aes_in);
      repeat (10) @(posedge clk);
      #1;
      aes_done = 1'b1;
      aes_out  = aes_blk ^ KCONST;
      check("aes_in_stable", aes_in, aes_blk);
      @(posedge clk);
      #1;
      aes_done = 1'b0;
    end
  end

  // Output monitor: a word transfers at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && strm.out_valid && strm.out_ready) begin
      check("sb_has_entry", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        check("out_word", strm.out_data, mon_exp);
      end
    end
  end

  task automatic send_word(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    strm.in_valid = 1'b1;
    strm.in_data  = d;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (strm.in_ready) ok = 1'b1;
    end
    check("accept_in_time", 128'(ok), 128'd1);
    if (ok) begin
      if (widx == 0) begin
        exp_ks  = exp_ctr ^ KCONST;
        exp_ctr = exp_ctr + 128'd1;
      end
      sb_q.push_back(d ^ ksw(exp_ks, widx));
      widx = (widx + 1) % 4;
    end
    @(posedge clk);
    #1;
    strm.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    check(tag, busy, 1'b0);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [31:0] held;
    strm.in_valid  = 1'b0;
    strm.in_data   = 32'h0;
    strm.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", strm.out_valid, 1'b0);
    check("rst_out_data",  strm.out_data, 32'h0);
    check("rst_in_ready",  strm.in_ready, 1'b0);
    check("rst_busy",      busy, 1'b0);
    check("rst_blk_count", blk_count, 32'h0);
    check("rst_aes_start", aes_start, 1'b0);
    check("rst_aes_in",    aes_in, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic block: counter 0, keystream = KCONST, zero data
    enable = 1'b1;
    send_word(32'h0);
    check("basic_w0", strm.out_data, 32'h33221100);
    enable = 1'b0;
    send_word(32'h0);
    check("basic_w1", strm.out_data, 32'h77665544);
    send_word(32'h0);
    check("basic_w2", strm.out_data, 32'hbbaa9988);
    send_word(32'h0);
    check("basic_w3", strm.out_data, 32'hffeeddcc);
    wait_idle("basic_idle");
    check("basic_one_inc",  inc_cnt, 1);
    check("basic_blk_cnt",  blk_count, 32'd1);
    check("basic_aes_in",   ain_q[0], 128'h0);

    // Back-to-back: 8 words, two launches
    s0 = starts;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word($urandom);
      if (i == 3) check("b2b_no_gap", aes_start, 1'b1);
      if (i == 4) enable = 1'b0;
    end
    wait_idle("b2b_idle");
    check("b2b_starts",    starts - s0, 2);
    check("b2b_blk_cnt",   blk_count, 32'd3);
    check("b2b_ctr_step",  ain_q[ain_q.size()-1], ain_q[ain_q.size()-2] + 128'd1);
    check("b2b_ctr_value", ain_q[ain_q.size()-1], 128'd2);

    // Backpressure: output stalled for 5 cycles after first accept
    enable = 1'b1;
    strm.out_ready = 1'b0;
    send_word(32'hdeadbeef);
    enable = 1'b0;
    held = sb_q[0];
    strm.in_valid = 1'b1;
    strm.in_data  = 32'h01234567;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", strm.in_ready, 1'b0);
      check("bp_held",     strm.out_data, held);
    end
    @(posedge clk);
    #1;
    strm.in_valid  = 1'b0;
    strm.out_ready = 1'b1;
    send_word(32'h01234567);
    send_word(32'h89abcdef);
    send_word(32'h55aa55aa);
    wait_idle("bp_idle");

    // Flush during WAIT; the late aes_done must be ignored
    s0 = starts;
    enable = 1'b1;
    strm.in_valid = 1'b1;
    strm.in_data  = 32'h0;
    for (int c = 0; c < 10 && !aes_start; c++) @(negedge clk);
    check("fl_launch", aes_start, 1'b1);
    strm.in_valid = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("fl_in_ready", strm.in_ready, 1'b0);
    check("fl_busy",     busy, 1'b0);
    exp_ctr = exp_ctr + 128'd1;
    repeat (12) @(posedge clk);
    #1;
    check("fl_late_busy",     busy, 1'b0);
    check("fl_late_in_ready", strm.in_ready, 1'b0);
    check("fl_late_out_vld",  strm.out_valid, 1'b0);
    enable = 1'b1;
    send_word(32'hcafef00d);
    enable = 1'b0;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    wait_idle("fl_idle");
    check("fl_starts", starts - s0, 2);

    // Enable dropped at idx 2: block completes, no new launch
    s0 = starts;
    enable = 1'b1;
    send_word(32'ha5a5a5a5);
    send_word(32'h5a5a5a5a);
    enable = 1'b0;
    send_word(32'h0f0f0f0f);
    send_word(32'hf0f0f0f0);
    wait_idle("en_idle");
    check("en_starts",   starts - s0, 1);
    check("en_in_ready", strm.in_ready, 1'b0);

    // Async reset mid-STREAM, between clock edges
    enable = 1'b1;
    send_word(32'h12345678);
    enable = 1'b0;
    send_word(32'h9abcdef0);
    strm.out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", strm.out_valid, 1'b0);
    check("arst_out_data",  strm.out_data, 32'h0);
    check("arst_busy",      busy, 1'b0);
    check("arst_blk_count", blk_count, 32'h0);
    check("arst_in_ready",  strm.in_ready, 1'b0);
    check("arst_aes_in",    aes_in, 128'h0);
    sb_q.delete();
    widx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    strm.out_ready = 1'b1;
    enable = 1'b1;
    send_word(32'h0badc0de);
    enable = 1'b0;
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    wait_idle("arst_idle");
    check("arst_blk_restart", blk_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
